seg7_scan_reader: RTL

//  Reads a multiplexed common-anode 7-segment display bus and recovers the hex digit shown on each position.
//  It is the inverse of the team's hex-to-7seg decoder: a pattern is accepted only after it has been stable for a set time.

---
 rtl/seg7_scan_reader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
// ============================================================================
// seg7_scan_reader : recovers hex digits from a multiplexed common-anode
// 7-segment bus. Optional decimal-point capture is enabled by SEG7_DP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_reader #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an_n,
  input  logic [6:0]        seg_n,
`ifdef SEG7_DP_EN
  input  logic              dp_n,
  output logic [NDIG-1:0]   dps,
  output logic              upd_dp,
`endif
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_valid,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [2:0]        upd_idx,
  output logic [3:0]        upd_hex,
  output logic              pat_err,
  output logic              ovf
);

`ifdef SEG7_DP_EN
  localparam int SW = NDIG + 8;
`else
  localparam int SW = NDIG + 7;
`endif
  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_LOCKED = 2'd2} state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [NDIG-1:0]   r_an_s1, r_an_s2;
  logic [6:0]        r_seg_s1, r_seg_s2;
  logic [SW-1:0]     w_sample;
  logic [SW-1:0]     r_lat, w_lat_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  state_t            r_state, w_state_nx;
  logic              w_cap;
  logic [3:0]        w_zcnt;
  logic [2:0]        w_idx;
  logic [4:0]        w_dec;
  logic              w_good, w_bad, w_hs;

  logic [4*NDIG-1:0] r_digits;
  logic [NDIG-1:0]   r_dv;
  logic              r_cap_pend;
  logic [2:0]        r_cap_idx;
  logic [3:0]        r_cap_hex;
  logic              r_upd_valid;
  logic [2:0]        r_upd_idx;
  logic [3:0]        r_upd_hex;
  logic              r_pat_err, r_ovf;

`ifdef SEG7_DP_EN
  logic              r_dp_s1, r_dp_s2;
  logic [NDIG-1:0]   r_dps;
  logic              r_cap_dp, r_upd_dp;
  assign w_sample = {r_an_s2, r_seg_s2, r_dp_s2};
`else
  assign w_sample = {r_an_s2, r_seg_s2};
`endif

  // Idle (all anodes high) synchroniser value keeps the FSM quiet out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
    end else begin
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_s1 <= 1'b1;
      r_dp_s2 <= 1'b1;
    end else begin
      r_dp_s1 <= dp_n;
      r_dp_s2 <= r_dp_s1;
    end
  end
`endif

  always_comb begin
    w_zcnt = 4'd0;
    w_idx  = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_an_s2[i]) begin
        w_zcnt = w_zcnt + 4'd1;
        w_idx  = 3'(i);
      end
    end
  end

  // Multi-anode patterns are tracked too, so their stability can be flagged,
  // but they never produce a capture.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lat_nx   = r_lat;
    w_cap      = 1'b0;
    if (r_state == S_TRACK && w_sample == r_lat) begin
      w_cnt_nx = r_cnt + 8'd1;
      if (r_cnt + 8'd1 == C_STABLE) begin
        w_cap      = 1'b1;
        w_state_nx = S_LOCKED;
      end
    end else if (r_state != S_LOCKED || w_sample != r_lat) begin
      if (&r_an_s2) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 8'd0;
      end else begin
        w_state_nx = S_TRACK;
        w_lat_nx   = w_sample;
        w_cnt_nx   = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_lat   <= '1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_lat   <= w_lat_nx;
    end
  end

  assign w_dec  = seg_decode(r_seg_s2);
  assign w_good = w_cap && (w_zcnt == 4'd1) && w_dec[4];
  assign w_bad  = w_cap && !((w_zcnt == 4'd1) && w_dec[4]);
  assign w_hs   = r_upd_valid && upd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits   <= '0;
      r_dv       <= '0;
      r_pat_err  <= 1'b0;
      r_cap_pend <= 1'b0;
      r_cap_idx  <= 3'd0;
      r_cap_hex  <= 4'd0;
    end else begin
      r_cap_pend <= w_good;
      if (w_good) begin
        r_cap_idx <= w_idx;
        r_cap_hex <= w_dec[3:0];
      end
      if (w_bad) r_pat_err <= 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (w_good && w_idx == 3'(i)) begin
          r_digits[4*i +: 4] <= w_dec[3:0];
          r_dv[i]            <= 1'b1;
        end
      end
    end
  end

  // One-deep update slot; a reload in the handshake cycle keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid <= 1'b0;
      r_upd_idx   <= 3'd0;
      r_upd_hex   <= 4'd0;
      r_ovf       <= 1'b0;
    end else if (r_cap_pend) begin
      if (!r_upd_valid || w_hs) begin
        r_upd_valid <= 1'b1;
        r_upd_idx   <= r_cap_idx;
        r_upd_hex   <= r_cap_hex;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_hs) begin
      r_upd_valid <= 1'b0;
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dps    <= '0;
      r_cap_dp <= 1'b0;
      r_upd_dp <= 1'b0;
    end else begin
      if (w_good) r_cap_dp <= ~r_dp_s2;
      if (r_cap_pend && (!r_upd_valid || w_hs)) r_upd_dp <= r_cap_dp;
      for (int i = 0; i < NDIG; i++) begin
        if (w_good && w_idx == 3'(i)) r_dps[i] <= ~r_dp_s2;
      end
    end
  end
  assign dps    = r_dps;
  assign upd_dp = r_upd_dp;
`endif

  assign digits    = r_digits;
  assign dig_valid = r_dv;
  assign upd_valid = r_upd_valid;
  assign upd_idx   = r_upd_idx;
  assign upd_hex   = r_upd_hex;
  assign pat_err   = r_pat_err;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
